// File: rtl/icache_pkg.sv
// Shared types, AXI constants and width helpers for the set-associative I-cache.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_HIT,
    S_AR,
    S_R,
    S_RESP,
    S_FLUSH
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_bytes, input int sets);
    return 32 - off_w(line_bytes) - idx_w(sets);
  endfunction

  // Width of a counter/pointer over n items, never zero.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_buf.sv
// Assembles refill beats into one cache line, tracks bus errors
// and selects the requested word.
module icache_refill_buf
  import icache_pkg::*;
#(
  parameter int LINE_BYTES = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          beat,
  input  logic [63:0]                   beat_data,
  input  logic [1:0]                    beat_resp,
  input  logic [off_w(LINE_BYTES)-3:0]  word_sel,
  output logic [LINE_BYTES*8-1:0]       line,
  output logic                          err,
  output logic [31:0]                   word
);

  localparam int BEATS  = LINE_BYTES / 8;
  localparam int BEAT_W = ptr_w(BEATS);

  logic [BEAT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt  <= '0;
      err  <= 1'b0;
      line <= '0;
    end else if (beat) begin
      line[{cnt, 6'b0} +: 64] <= beat_data;
      cnt <= (BEATS == 1) ? '0 : cnt + 1'b1;
      if (beat_resp != RESP_OKAY) err <= 1'b1;
    end
  end

  assign word = line[{word_sel, 5'b0} +: 32];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: fetch-side AR/R slave, AXI burst
// refill master, round-robin replacement, deferred flush, hit/miss counters.
module icache_sa
  import icache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 16,
  parameter int AXI_ID     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic        rerr_o,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(LINE_BYTES, SETS);
  localparam int WAY_W  = ptr_w(WAYS);
  localparam int LINE_W = LINE_BYTES * 8;

  state_t state, state_n;

  logic [31:0]       addr_q;
  logic              flush_pending;
  logic [WAY_W-1:0]  hit_way_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]  ptr_q   [SETS];

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [OFF_W-3:0]   wsel;
  logic               hit_any, free_any;
  logic [WAY_W-1:0]   hit_way, free_way, fill_way;
  logic               accept, beat, install;
  logic [LINE_W-1:0]  buf_line;
  logic               buf_err;
  logic [31:0]        buf_word;
  logic               unused_bits;

  assign idx  = addr_q[OFF_W +: IDX_W];
  assign tag  = addr_q[31 -: TAG_W];
  assign wsel = addr_q[2 +: OFF_W-2];
  assign unused_bits = ^addr_q[1:0];

  assign accept  = arvalid_i && arready_o;
  assign beat    = (state == S_R) && io_master_rvalid
                && (io_master_rid == 4'(AXI_ID));
  assign install = (state == S_RESP) && rready_i && !buf_err;

  // Downward scan leaves the lowest matching/free way selected.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    free_any = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        free_any = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign fill_way = free_any ? free_way : ptr_q[idx];

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept) state_n = S_LOOKUP;
        else if (flush_i || flush_pending) state_n = S_FLUSH;
      S_LOOKUP:
        state_n = hit_any ? S_HIT : S_AR;
      S_HIT:
        if (rready_i)
          state_n = (flush_pending || flush_i) ? S_FLUSH : S_IDLE;
      S_AR:
        if (io_master_arready) state_n = S_R;
      S_R:
        if (beat && io_master_rlast) state_n = S_RESP;
      S_RESP:
        if (rready_i)
          state_n = (flush_pending || flush_i) ? S_FLUSH : S_IDLE;
      S_FLUSH:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      flush_pending <= 1'b0;
      hit_way_q     <= '0;
      hit_count_o   <= '0;
      miss_count_o  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state <= state_n;
      if (state == S_IDLE && accept) addr_q <= araddr_i;
      if (state == S_FLUSH) flush_pending <= 1'b0;
      else if (flush_i && state_n != S_FLUSH) flush_pending <= 1'b1;
      if (state == S_LOOKUP) begin
        if (hit_any) begin
          hit_count_o <= hit_count_o + 32'd1;
          hit_way_q   <= hit_way;
        end else begin
          miss_count_o <= miss_count_o + 32'd1;
        end
      end
      if (state == S_FLUSH) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          ptr_q[s]   <= '0;
        end
      end
      if (install) begin
        valid_q[idx][fill_way] <= 1'b1;
        if (!free_any)
          ptr_q[idx] <= (ptr_q[idx] == WAY_W'(WAYS - 1))
                      ? '0 : ptr_q[idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (install) begin
      tag_q[idx][fill_way]  <= tag;
      data_q[idx][fill_way] <= buf_line;
    end
  end

  icache_refill_buf #(
    .LINE_BYTES (LINE_BYTES)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .clear     (state == S_AR),
    .beat      (beat),
    .beat_data (io_master_rdata),
    .beat_resp (io_master_rresp),
    .word_sel  (wsel),
    .line      (buf_line),
    .err       (buf_err),
    .word      (buf_word)
  );

  assign arready_o = (state == S_IDLE) && !flush_pending && !reset;
  assign rvalid_o  = (state == S_HIT) || (state == S_RESP);
  assign rerr_o    = (state == S_RESP) && buf_err;

  always_comb begin
    rdata_o = '0;
    if (state == S_HIT)
      rdata_o = data_q[idx][hit_way_q][{wsel, 5'b0} +: 32];
    else if (state == S_RESP)
      rdata_o = buf_word;
  end

  assign io_master_arvalid = (state == S_AR);
  assign io_master_araddr  = {addr_q[31:OFF_W], OFF_W'(0)};
  assign io_master_arid    = 4'(AXI_ID);
  assign io_master_arlen   = 8'(LINE_BYTES / 8 - 1);
  assign io_master_arsize  = SIZE_8B;
  assign io_master_arburst = BURST_INCR;
  assign io_master_rready  = (state == S_R);

endmodule
